// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite encodings, slave FSM states and byte-lane helpers for the
// memory-backed slave responder.
package ahbl_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'd0,
        HSIZE_HALF = 3'd1,
        HSIZE_WORD = 3'd2
    } hsize_t;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } slv_state_t;

    // Little-endian byte enables for a transfer of the given size at addr_lo.
    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] addr_lo);
        logic [3:0] mask;
        case (size)
            HSIZE_BYTE: mask = 4'b0001 << addr_lo;
            HSIZE_HALF: mask = addr_lo[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: mask = 4'b1111;
            default:    mask = 4'b0000;
        endcase
        return mask;
    endfunction

    function automatic logic size_misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            HSIZE_HALF: mis = addr_lo[0];
            HSIZE_WORD: mis = |addr_lo;
            default:    mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/ahbl_slave_mem_array.sv
// Word-addressed flop memory: one byte-wide array per lane so each lane has
// its own write enable; read is combinational.
module ahbl_slave_mem_array #(
    parameter int WORDS = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [WORDS];

            always_ff @(posedge clk) begin
                if (we && be[gi]) begin
                    lane_mem[addr] <= wdata[8*gi +: 8];
                end
            end

            assign rdata[8*gi +: 8] = lane_mem[addr];
        end
    endgenerate

endmodule

// File: rtl/ahbl_slave_mem.sv
// AHB-Lite slave with flop memory, programmable wait states and the
// two-cycle ERROR response for out-of-range, misaligned or oversized beats.
module ahbl_slave_mem
    import ahbl_pkg::*;
#(
    parameter int MEM_BYTES   = 1024,
    parameter int DEC_BITS    = 12,
    parameter int WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESETN,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);

    localparam int MEM_AW  = $clog2(MEM_BYTES);
    localparam int WORD_AW = (MEM_AW > 2) ? MEM_AW - 2 : 1;
    localparam int WORDS   = MEM_BYTES / 4;
    localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    slv_state_t          state_reg;
    logic [3:0]          cnt_reg;
    logic [MEM_AW-1:0]   addr_reg;
    logic                write_reg;
    logic [2:0]          size_reg;
    logic                err_reg;
    logic                dphase_reg;
    logic                hreadyout_reg;
    logic                hresp_reg;

    logic                addr_phase_valid;
    logic                out_of_range;
    logic                req_err;
    logic                data_done;
    logic [WORD_AW-1:0]  word_idx;
    logic [31:0]         mem_rdata;
    logic                unused_bits;

    // BURST is irrelevant since every beat is handled on its own; upper
    // address bits beyond the decoded window are ignored.
    assign unused_bits = ^{HBURST, HADDR[31:MEM_AW]};

    assign addr_phase_valid = HSEL && HREADY &&
                              ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));

    generate
        if (DEC_BITS > MEM_AW) begin : g_range
            assign out_of_range = |HADDR[DEC_BITS-1:MEM_AW];
        end else begin : g_full
            assign out_of_range = 1'b0;
        end
    endgenerate

    assign req_err = (HSIZE > HSIZE_WORD) || size_misaligned(HSIZE, HADDR[1:0]) || out_of_range;

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= 4'd0;
            addr_reg      <= '0;
            write_reg     <= 1'b0;
            size_reg      <= 3'd0;
            err_reg       <= 1'b0;
            dphase_reg    <= 1'b0;
            hreadyout_reg <= 1'b1;
            hresp_reg     <= HRESP_OKAY;
        end else begin
            case (state_reg)
                ST_WAIT: begin
                    if (cnt_reg == 4'd0) begin
                        state_reg     <= ST_IDLE;
                        hreadyout_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                ST_ERR1: begin
                    state_reg     <= ST_ERR2;
                    hreadyout_reg <= 1'b1;
                    hresp_reg     <= HRESP_ERROR;
                end
                default: begin
                    // IDLE and ERR2 both drive HREADYOUT=1, so a new address
                    // phase can be taken here.
                    state_reg     <= ST_IDLE;
                    dphase_reg    <= 1'b0;
                    hreadyout_reg <= 1'b1;
                    hresp_reg     <= HRESP_OKAY;
                    if (addr_phase_valid) begin
                        addr_reg  <= HADDR[MEM_AW-1:0];
                        write_reg <= HWRITE;
                        size_reg  <= HSIZE;
                        err_reg   <= req_err;
                        if (req_err) begin
                            state_reg     <= ST_ERR1;
                            hreadyout_reg <= 1'b0;
                            hresp_reg     <= HRESP_ERROR;
                        end else begin
                            dphase_reg <= 1'b1;
                            if (WAIT_STATES > 0) begin
                                state_reg     <= ST_WAIT;
                                cnt_reg       <= WAIT_INIT;
                                hreadyout_reg <= 1'b0;
                            end
                        end
                    end
                end
            endcase
        end
    end

    // The OKAY data phase completes in the first IDLE cycle after capture
    // (or after the last wait cycle).
    assign data_done = dphase_reg && (state_reg == ST_IDLE) && !err_reg;

    generate
        if (MEM_AW > 2) begin : g_widx
            assign word_idx = addr_reg[MEM_AW-1:2];
        end else begin : g_widx_one
            assign word_idx = '0;
        end
    endgenerate

    ahbl_slave_mem_array #(
        .WORDS (WORDS),
        .AW    (WORD_AW)
    ) u_array (
        .clk   (HCLK),
        .we    (data_done && write_reg),
        .be    (lane_mask(size_reg, addr_reg[1:0])),
        .addr  (word_idx),
        .wdata (HWDATA),
        .rdata (mem_rdata)
    );

    assign HRDATA    = (data_done && !write_reg) ? mem_rdata : 32'd0;
    assign HREADYOUT = hreadyout_reg;
    assign HRESP     = hresp_reg;

endmodule
